// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with mid-bit sampling feeding a
// first-word-fall-through byte FIFO with a valid/ready consumer interface.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the parity_err output.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     uart_rx,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_err,
    output logic                     overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] Full     = LW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
`ifdef UART_RX_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_meta;
    logic          rx_s;
    state_e        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_req;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: start qualification, bit sampling, stop check, error pulses.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= StStart;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                StStart: begin
                    if (cnt == HalfLast) begin
                        if (rx_s) begin
                            state <= StIdle;
                        end else begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= StData;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Sampling point is now mid-bit; one full bit period per sample.
                StData: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                StParity: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        par_bad <= ^{shreg, rx_s};
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // Frame error wins over parity error; a bad byte is never pushed.
                StStop: begin
                    if (cnt == BitLast) begin
                        cnt <= '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                push_req <= 1'b1;
                            end
`else
                            push_req <= 1'b1;
`endif
                            state <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitHigh;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold off until the line returns high so a break yields no bytes.
                StWaitHigh: begin
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          pop;
    logic          full;
    logic          do_write;

    assign rx_valid   = (level != '0);
    assign rx_data    = mem[rd_ptr];
    assign fifo_level = level;

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    always_comb begin
        pop      = rx_valid && rx_ready;
        full     = (level == Full);
        do_write = push_req && (!full || pop);
    end

    // Storage, pointers, occupancy and the overrun pulse.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (do_write) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (CLKS_PER_BIT=8, DEPTH=4, 8N1 build).
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rstb     = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_level;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .fifo_level(fifo_level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Observed traffic, sampled mid-cycle; inputs change just after posedge.
    logic [7:0] got[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcyc   = 0;

    always @(negedge clk) begin
        if (rstb) begin
            if (rx_valid) vcyc++;
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive frame bits LSB first, CPB cycles each, for ncyc cycles total.
    task automatic send_bits(input logic [9:0] f, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            uart_rx = f[c / CPB];
            step(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits({stop, d, 1'b0}, 10 * CPB);
        uart_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_fe;
        int         exp_pop;
    } vec_t;

    vec_t vecs[5];
    int g0, f0, o0, v0;
    logic [7:0] exp_b;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 0, 1};
        vecs[3] = '{8'h3C, 1'b0, 1, 0};
        vecs[4] = '{8'h55, 1'b1, 0, 1};

        // Reset state
        rstb = 1'b0;
        step(3);
        rstb = 1'b1;
        step(2);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_overrun", int'(overrun), 0);

        // Table: single frames with rx_ready=1; bad stop followed by a long low.
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            g0 = got.size();
            f0 = fe_cnt;
            o0 = ov_cnt;
            v0 = vcyc;
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                uart_rx = 1'b0;
                step(40);
                uart_rx = 1'b1;
            end
            step(30);
            chk("vec_pop_count", got.size() - g0, vecs[i].exp_pop);
            if (vecs[i].exp_pop == 1 && got.size() > g0)
                chk("vec_pop_data", int'(got[g0]), int'(vecs[i].data));
            chk("vec_valid_cycles", vcyc - v0, vecs[i].exp_pop);
            chk("vec_frame_err", fe_cnt - f0, vecs[i].exp_fe);
            chk("vec_overrun", ov_cnt - o0, 0);
            chk("vec_level", int'(fifo_level), 0);
        end

        // Start-bit glitch: 3 clocks low must not start a frame.
        g0 = got.size();
        f0 = fe_cnt;
        v0 = vcyc;
        uart_rx = 1'b0;
        step(3);
        uart_rx = 1'b1;
        step(100);
        chk("glitch_valid_cycles", vcyc - v0, 0);
        chk("glitch_level", int'(fifo_level), 0);
        chk("glitch_frame_err", fe_cnt - f0, 0);
        send_frame(8'h81, 1'b1);
        step(20);
        chk("glitch_next_count", got.size() - g0, 1);
        chk("glitch_next_data", int'(got[g0]), 8'h81);

        // Overrun: fill with rx_ready low, fifth byte dropped.
        rx_ready = 1'b0;
        o0 = ov_cnt;
        f0 = fe_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1);
            step(16);
            chk("ovr_level", int'(fifo_level), (k < DEPTH) ? k : DEPTH);
        end
        chk("ovr_pulses", ov_cnt - o0, 1);
        chk("ovr_frame_err", fe_cnt - f0, 0);
        g0 = got.size();
        rx_ready = 1'b1;
        step(10);
        chk("ovr_drain_count", got.size() - g0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("ovr_drain_data", int'(got[g0 + k]), k + 1);
        end
        chk("ovr_drain_level", int'(fifo_level), 0);

        // Full FIFO, pop raised exactly on the push cycle of the fifth byte.
        rx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_frame(8'h10 + 8'(k), 1'b1);
            step(16);
        end
        chk("sim_full_level", int'(fifo_level), 4);
        g0 = got.size();
        o0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                step(79);
                rx_ready = 1'b1;
            end
        join
        chk("sim_level_after_push", int'(fifo_level), 4);
        step(10);
        chk("sim_overrun", ov_cnt - o0, 0);
        chk("sim_drain_count", got.size() - g0, 5);
        for (int k = 0; k < 5; k++) begin
            exp_b = (k < 4) ? 8'h10 + 8'(k) : 8'h77;
            chk("sim_drain_data", int'(got[g0 + k]), int'(exp_b));
        end
        chk("sim_drain_level", int'(fifo_level), 0);

        // Reset mid-frame (data bit 4) with a byte parked in the FIFO.
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        step(16);
        chk("rst_pre_level", int'(fifo_level), 1);
        send_bits({1'b1, 8'h5A, 1'b0}, 5 * CPB + 4);
        uart_rx = 1'b1;
        rstb    = 1'b0;
        step(1);
        rstb    = 1'b1;
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        rx_ready = 1'b1;
        g0 = got.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        step(20);
        chk("rst_no_partial", got.size() - g0, 0);
        send_frame(8'hC3, 1'b1);
        step(20);
        chk("rst_next_count", got.size() - g0, 1);
        chk("rst_next_data", int'(got[g0]), 8'hC3);
        chk("rst_next_frame_err", fe_cnt - f0, 0);
        chk("rst_next_overrun", ov_cnt - o0, 0);
        chk("rst_next_level", int'(fifo_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
